wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback result (requester A) and a long-latency unit return path (requester B, e.g. multi-cycle load or mul/div). B results are buffered in a small FIFO; A has priority, but a starvation counter forces a B grant after a bounded wait by back-pressuring A. A scoreboard of registers with outstanding B writes is exported for hazard detection in decode.

## Interface
- `DEPTH`, 2: B FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 3: max consecutive A grants while the FIFO is non-empty (≥1).
- Clocking: one clock; reset is synchronous and active-high.
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: synchronous active-high reset.
- `a_valid` input 1: A write request.
- `a_rd` input 5: A destination register.
- `a_data` input 32: A write data.
- `a_ready` output 1: A accepted this cycle when `a_valid & a_ready`.
- `b_valid` input 1: B result available.
- `b_rd` input 5: B destination.
- `b_data` input 32: B write data.
- `b_ready` output 1: FIFO not full.
- `b_issue` input 1: long-latency op issued this cycle.
- `b_issue_rd` input 5: its destination.
- `pending_mask` output 32: bit r set while register r has an outstanding B write.
- `rf_we` output 1: registered register-file write enable.
- `rf_waddr` output 5: registered write address.
- `rf_wdata` output 32: registered write data.

## Operation
- `b_ready = !full`. No pass-through: a full FIFO refuses B even if dequeuing the same cycle.
- B enqueues on `b_valid & b_ready`. An entry is grant-eligible from the cycle after enqueue.
- `force = (starve_cnt == STARVE_LIMIT)`.
- `a_ready = !force`.
- Grant rule, each cycle:
  - If `force`: grant the FIFO head. The FIFO is non-empty by construction.
  - Else if `a_valid`: grant A.
  - Else if the FIFO is non-empty: grant the FIFO head.
  - Else: no grant.
- `starve_cnt` update:
  - +1 when A is granted and the FIFO is non-empty.
  - Reset to 0 on any B grant or when the FIFO is empty.
  - Otherwise hold.
  - Width is clog2(STARVE_LIMIT+1).
- Granted write registers into `rf_we/rf_waddr/rf_wdata` at the next edge.
  - A grant or B grant with rd = 0 still consumes the request, but drives `rf_we = 0`.
  - When there is no grant, `rf_we = 0`; `rf_waddr` and `rf_wdata` hold their previous values.
- Scoreboard behaviour:
  - `b_issue` with rd ≠ 0 sets `pending_mask[rd]`.
  - A B grant clears the bit for its rd.
  - Set and clear of the same rd in the same cycle: set wins (a new op is in flight).
  - `b_issue_rd = 0` is ignored.
- The pipeline must not issue A writes to a register whose `pending_mask` bit is set. The arbiter does not check this.
- FIFO pointers use DEPTH-wrap with an extra bit to distinguish full from empty. Simultaneous enqueue and dequeue when neither full nor empty: the count is unchanged.

## Timing
- Reset values (applied on the `i_rst` edge; reset mid-operation discards the FIFO contents and all pending bits):
  - FIFO empty.
  - `starve_cnt = 0`.
  - `pending_mask = 0`.
  - `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`.
- While `i_rst` is high: `a_ready = 1` and `b_ready = 1`, but nothing is recorded.
- A latency: accepted at cycle t → `rf_we` is high during t+1.
- B latency: enqueued at t → earliest grant at t+1 → `rf_we` at t+2.
- B worst-case wait from head-of-FIFO to grant: STARVE_LIMIT cycles of A traffic, then one forced cycle.
- `a_ready` and `b_ready` are combinational from registered state only. Neither depends on `a_valid` or `b_valid`.
- `pending_mask` updates one edge after issue or grant.
  - An issue at t is visible at t+1.
  - A bit cleared by a grant at t reads 0 at t+1, the same cycle `rf_we` commits.

## Test plan
- **Reset:**
  - Stimulus: hold `i_rst` for 2 cycles with `a_valid = b_valid = 1`.
  - Required: `rf_we = 0`, `pending_mask = 0`, FIFO empty afterward. The first post-reset A write appears exactly one cycle later.
- **A-only stream:**
  - Stimulus: A writes x5=0x11 and x6=0x22 on back-to-back cycles.
  - Required: `rf_we` high two cycles with (5, 0x11) then (6, 0x22); `a_ready` stays 1.
- **Starvation:**
  - Stimulus: STARVE_LIMIT=3; B enqueues x7=0xAA at t; `a_valid` held high continuously from t.
  - Required: A granted at t, t+1, t+2 (`starve_cnt` reaches 3); `a_ready = 0` at t+3 and B granted; `rf_waddr = 7`, `rf_wdata = 0xAA` at t+4; A resumes at t+4.
- **FIFO full:**
  - Stimulus: DEPTH=2; A continuously valid; B offers 3 results back to back.
  - Required: `b_ready` drops after 2 enqueues and the third waits. All three commit in order with the same data.
- **Scoreboard:**
  - Stimulus: `b_issue` x9 at t.
  - Required: `pending_mask[9] = 1` at t+1. Clears the cycle the x9 write commits.
  - Stimulus: in the same cycle as the x9 clear, issue x9 again.
  - Required: the bit stays 1.
- **x0 handling:**
  - Stimulus: B result to x0; `b_issue_rd = 0`.
  - Required: request consumed, `rf_we = 0` that slot, `pending_mask[0]` always 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) versus a buffered
// long-latency return path (B), with starvation forcing and a pending-write scoreboard.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        b_issue,
  input  logic [4:0]  b_issue_rd,
  output logic [31:0] pending_mask,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   pending_next;
  logic          empty, full, force_b, b_push, grant_a, grant_b;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_rd   = fifo_rd[rd_ptr[AW-1:0]];
  assign head_data = fifo_data[rd_ptr[AW-1:0]];
  assign force_b   = (starve_cnt == SW'(STARVE_LIMIT));

  // Handshakes depend only on registered state; reset keeps both ports open without recording.
  assign a_ready = i_rst | ~force_b;
  assign b_ready = i_rst | ~full;
  assign b_push  = b_valid & ~full & ~i_rst;
  assign grant_a = a_valid & ~force_b;
  assign grant_b = ~empty & (force_b | ~a_valid);

  always_ff @(posedge i_clk) begin
    if (b_push) begin
      fifo_rd[wr_ptr[AW-1:0]]   <= b_rd;
      fifo_data[wr_ptr[AW-1:0]] <= b_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (b_push)  wr_ptr <= wr_ptr + 1'b1;
      if (grant_b) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // An entry enqueued this cycle already counts as waiting, so B waits at most STARVE_LIMIT A grants.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (grant_b || (empty && !b_push)) begin
      starve_cnt <= '0;
    end else if (grant_a) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant_a) begin
      rf_we    <= (a_rd != 5'd0);
      rf_waddr <= a_rd;
      rf_wdata <= a_data;
    end else if (grant_b) begin
      rf_we    <= (head_rd != 5'd0);
      rf_waddr <= head_rd;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // A fresh issue to the register being retired wins, since a newer op is now in flight.
  always_comb begin
    pending_next = pending_mask;
    if (grant_b && head_rd != 5'd0) pending_next[head_rd] = 1'b0;
    if (b_issue && b_issue_rd != 5'd0) pending_next[b_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) pending_mask <= '0;
    else       pending_mask <= pending_next;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter; expected register-file writes are queued
// when each cycle's stimulus is driven and checked after the following edge.
module tb_wb_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        a_valid, b_valid, b_issue;
  logic [4:0]  a_rd, b_rd, b_issue_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pending_mask;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .b_issue(b_issue), .b_issue_rd(b_issue_rd), .pending_mask(pending_mask),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic rst; logic av; logic [4:0] ard; logic [31:0] adat;
    logic bv; logic [4:0] brd; logic [31:0] bdat; logic bi; logic [4:0] bird;
    logic ear; logic ebr; logic ewe; logic [4:0] ewa; logic [31:0] ewd;
    logic chk; logic [31:0] emask;
  } vec_t;

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic chk; logic [31:0] mask;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rst, logic av, logic [4:0] ard, logic [31:0] adat,
                              logic bv, logic [4:0] brd, logic [31:0] bdat,
                              logic bi, logic [4:0] bird, logic ear, logic ebr,
                              logic ewe, logic [4:0] ewa, logic [31:0] ewd,
                              logic chk, logic [31:0] emask);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
    v.bv = bv; v.brd = brd; v.bdat = bdat; v.bi = bi; v.bird = bird;
    v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    v.chk = chk; v.emask = emask;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL row%0d scoreboard empty actual=0 required=1", idx);
      return;
    end
    e = exp_q.pop_front();
    cmp($sformatf("row%0d rf_we", idx), {31'd0, rf_we}, {31'd0, e.we});
    if (e.we || e.chk) begin
      cmp($sformatf("row%0d rf_waddr", idx), {27'd0, rf_waddr}, {27'd0, e.wa});
      cmp($sformatf("row%0d rf_wdata", idx), rf_wdata, e.wd);
    end
    cmp($sformatf("row%0d pending_mask", idx), pending_mask, e.mask);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    i_rst = v.rst; a_valid = v.av; a_rd = v.ard; a_data = v.adat;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bdat; b_issue = v.bi; b_issue_rd = v.bird;
    #1;
    cmp($sformatf("row%0d a_ready", idx), {31'd0, a_ready}, {31'd0, v.ear});
    cmp($sformatf("row%0d b_ready", idx), {31'd0, b_ready}, {31'd0, v.ebr});
    e.we = v.ewe; e.wa = v.ewa; e.wd = v.ewd; e.chk = v.chk; e.mask = v.emask;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    checkOutput(idx);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset held two cycles with both requesters active and an issue pending.
    vecs.push_back(mk(1, 1,5,32'h77, 1,6,32'h66, 1,9,  1,1, 0,0,0,       1, 32'h0));
    vecs.push_back(mk(1, 1,5,32'h77, 1,6,32'h66, 1,9,  1,1, 0,0,0,       1, 32'h0));
    // A-only stream, then an idle cycle that also proves the FIFO came out of reset empty.
    vecs.push_back(mk(0, 1,5,32'h11, 0,0,0,      0,0,  1,1, 1,5,32'h11,  0, 32'h0));
    vecs.push_back(mk(0, 1,6,32'h22, 0,0,0,      0,0,  1,1, 1,6,32'h22,  0, 32'h0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      1,7,  1,1, 0,6,32'h22,  1, 32'h80));
    // Starvation: B x7 enqueued while A is continuously valid.
    vecs.push_back(mk(0, 1,1,32'h101, 1,7,32'hAA, 0,0, 1,1, 1,1,32'h101, 0, 32'h80));
    vecs.push_back(mk(0, 1,2,32'h102, 0,0,0,      0,0, 1,1, 1,2,32'h102, 0, 32'h80));
    vecs.push_back(mk(0, 1,3,32'h103, 0,0,0,      0,0, 1,1, 1,3,32'h103, 0, 32'h80));
    vecs.push_back(mk(0, 1,4,32'h104, 0,0,0,      0,0, 0,1, 1,7,32'hAA,  1, 32'h0));
    vecs.push_back(mk(0, 1,4,32'h104, 0,0,0,      0,0, 1,1, 1,4,32'h104, 0, 32'h0));
    // FIFO full: three B results against continuous A traffic.
    vecs.push_back(mk(0, 1,10,32'hA0, 1,11,32'hB1, 0,0, 1,1, 1,10,32'hA0, 0, 32'h0));
    vecs.push_back(mk(0, 1,10,32'hA1, 1,12,32'hB2, 0,0, 1,1, 1,10,32'hA1, 0, 32'h0));
    vecs.push_back(mk(0, 1,10,32'hA2, 1,13,32'hB3, 0,0, 1,0, 1,10,32'hA2, 0, 32'h0));
    vecs.push_back(mk(0, 1,10,32'hA3, 1,13,32'hB3, 0,0, 0,0, 1,11,32'hB1, 0, 32'h0));
    vecs.push_back(mk(0, 1,10,32'hA3, 1,13,32'hB3, 0,0, 1,1, 1,10,32'hA3, 0, 32'h0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,       0,0, 1,0, 1,12,32'hB2, 0, 32'h0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,       0,0, 1,1, 1,13,32'hB3, 0, 32'h0));
    vecs.push_back(mk(0, 0,0,0,       0,0,0,       0,0, 1,1, 0,0,0,       0, 32'h0));
    // Scoreboard on x9: set, clear at commit, then re-issue on the clearing cycle.
    vecs.push_back(mk(0, 0,0,0, 0,0,0,       1,9, 1,1, 0,0,0,       0, 32'h200));
    vecs.push_back(mk(0, 0,0,0, 1,9,32'h99,  0,0, 1,1, 0,0,0,       0, 32'h200));
    vecs.push_back(mk(0, 0,0,0, 0,0,0,       0,0, 1,1, 1,9,32'h99,  0, 32'h0));
    vecs.push_back(mk(0, 0,0,0, 1,9,32'h98,  1,9, 1,1, 0,0,0,       0, 32'h200));
    vecs.push_back(mk(0, 0,0,0, 0,0,0,       1,9, 1,1, 1,9,32'h98,  0, 32'h200));
    vecs.push_back(mk(0, 0,0,0, 1,9,32'h97,  0,0, 1,1, 0,0,0,       0, 32'h200));
    vecs.push_back(mk(0, 0,0,0, 0,0,0,       0,0, 1,1, 1,9,32'h97,  0, 32'h0));
    // x0: B result and issue to x0 are consumed silently; x8 behind it proves the slot drained.
    vecs.push_back(mk(0, 0,0,0,      1,0,32'h55, 1,0, 1,1, 0,0,0,      0, 32'h0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,1, 0,0,0,      0, 32'h0));
    vecs.push_back(mk(0, 0,0,0,      1,8,32'h88, 0,0, 1,1, 0,0,0,      0, 32'h0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,1, 1,8,32'h88, 0, 32'h0));
    vecs.push_back(mk(0, 1,0,32'h5A, 0,0,0,      0,0, 1,1, 0,0,0,      0, 32'h0));
    // Reset mid-operation discards a buffered B result and its pending bit.
    vecs.push_back(mk(0, 0,0,0,      1,15,32'hF, 1,15, 1,1, 0,0,0,      0, 32'h8000));
    vecs.push_back(mk(1, 1,3,32'h33, 1,16,32'h66, 1,16, 1,1, 0,0,0,     1, 32'h0));
    vecs.push_back(mk(0, 0,0,0,      0,0,0,       0,0,  1,1, 0,0,0,     0, 32'h0));
    vecs.push_back(mk(0, 1,3,32'h33, 0,0,0,       0,0,  1,1, 1,3,32'h33, 0, 32'h0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
